r_exec_unit: RTL and testbench
==============================

Name: r_exec_unit

Overview:
- Parametrised successor to the single-cycle R-type ALU: executes all RV32I R-type ops plus, optionally, the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits in the execute stage of the multi-cycle/pipelined core, with valid/ready handshakes on both sides.
- Base ops complete in 1 cycle, multiplies in MUL_LATENCY cycles, and divides iteratively in XLEN+1 cycles.

Parameters:
- XLEN, 32: operand/result width; legal values 32 and 64.
- ENABLE_M, 1: 1 decodes M-extension ops; 0 flags them illegal.
- MUL_LATENCY, 2: cycles from accept to out_valid for MUL*; range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- in_func  in  5  {funct7[5], funct7[0], funct3}
- in_rs1  in  XLEN  operand 1
- in_rs2  in  XLEN  operand 2
- in_tag  in  5  destination register index, passed through
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  result
- out_tag  out  5  tag of the accepted op
- out_illegal  out  1  undecodable func; out_result=0

Behaviour:
- One op in flight.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready); the combinational out_ready->in_ready path is intentional and gives back-to-back throughput.
- Base ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shift amount is rs2[$clog2(XLEN)-1:0].
  - SLT/SLTU produce a zero-extended 0/1.
  - Accept in cycle N -> DONE with out_valid=1 in N+1.
- MUL ops:
  - Product is 2*XLEN wide, using signedness per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns the low half; MULH* return the high half.
  - Goes to MUL_BUSY, counter counts MUL_LATENCY-1 down; out_valid in cycle N+MUL_LATENCY. With MUL_LATENCY=1, go directly to DONE.
- DIV ops:
  - Fast path, 1 cycle:
    - Divisor 0 -> quotient all-ones, remainder = rs1.
    - Signed overflow (rs1 = most-negative, rs2 = -1) -> quotient = rs1, remainder 0.
  - Otherwise DIV_BUSY: restoring divider on magnitudes, one quotient bit per cycle for XLEN cycles, then one cycle for sign fixup. out_valid in N+XLEN+1.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder takes the sign of rs1.
- Illegal ops:
  - funct7[5]=1 with funct3 not in {000, 101}, or with funct7[0]=1.
  - funct7[0]=1 when ENABLE_M=0.
  - Result: DONE in 1 cycle, out_illegal=1, out_result=0.
- DONE:
  - out_valid, out_result, out_tag and out_illegal are held stable until out_ready.
  - On out_ready: go to IDLE, or load the next op if in_valid.
- in_func/in_rs*/in_tag are sampled only at accept; later changes are ignored.
- Reset (any state, including mid-divide): state=IDLE, out_valid=0, out_result=0, out_tag=0, out_illegal=0, counters=0. in_ready=1 in the first cycle after rst deasserts; while rst=1, in_ready=0.
- Signed arithmetic uses explicit $signed casts; no implicit width extension on compares.

Decomposition:
- Shared package (riscv_pkg):
  - Extend r_func to a 5-bit enum with MUL=5'b01000 … REMU=5'b01111.
  - Add exec_state_t.
  - Add XLEN_DEFAULT.
- Sub-module div_iter (XLEN param): start/busy/done, unsigned restoring core; sign handling and fast paths stay in r_exec_unit.

Test Plan:
- Base ops, back-to-back with out_ready=1: ADD 7+5 -> 12 at N+1; SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000>>>4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1. One result per cycle, in_ready stays high.
- MUL, MUL_LATENCY=2:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000 at N+2.
  - MULHSU(-1, 0xFFFFFFFF) -> 0xFFFFFFFF.
  - MULHU(0xFFFFFFFF, 0xFFFFFFFF) -> 0xFFFFFFFE.
- DIV:
  - DIV -7/2 -> 0xFFFFFFFD at N+33.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - in_ready=0 throughout the divide.
- Fast paths: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0. All at N+1.
- Backpressure and illegal ops:
  - out_ready=0 for 5 cycles: result and tag held, in_ready=0.
  - in_func 5'b11000 -> out_illegal=1, result 0.
  - ENABLE_M=0 with MUL -> illegal.
- Reset while DIV_BUSY at iteration 10 -> out_valid=0, then IDLE and in_ready=1 after deassert. The next op ADD 1+1 -> 2 is correct.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I/M definitions for the execute-stage units.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // {funct7[5], funct7[0], funct3}
    typedef enum logic [4:0] {
        ADD    = 5'b00000,
        SLL    = 5'b00001,
        SLT    = 5'b00010,
        SLTU   = 5'b00011,
        XOR    = 5'b00100,
        SRL    = 5'b00101,
        OR     = 5'b00110,
        AND    = 5'b00111,
        SUB    = 5'b10000,
        SRA    = 5'b10101,
        MUL    = 5'b01000,
        MULH   = 5'b01001,
        MULHSU = 5'b01010,
        MULHU  = 5'b01011,
        DIV    = 5'b01100,
        DIVU   = 5'b01101,
        REM    = 5'b01110,
        REMU   = 5'b01111
    } r_func_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DONE     = 2'd3
    } exec_state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// produced on the start edge, so quo/rem are final while done is high.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);
    localparam int CW = $clog2(XLEN + 1);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] r_in, q_in, d_in, r_nx, q_nx;
    logic [XLEN:0]   sh;
    logic            ge;

    // One restoring step; on start it operates on the fresh operands.
    always_comb begin
        r_in = start ? '0 : rem;
        q_in = start ? dividend : quo;
        d_in = start ? divisor : dvs;
        sh   = {r_in, q_in[XLEN-1]};
        ge   = (sh >= {1'b0, d_in});
        r_nx = ge ? XLEN'(sh - {1'b0, d_in}) : sh[XLEN-1:0];
        q_nx = {q_in[XLEN-2:0], ge};
    end

    assign done = busy && (cnt == '0);

    // Iteration registers; remaining XLEN-1 steps after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(XLEN - 1);
            quo  <= q_nx;
            rem  <= r_nx;
            dvs  <= divisor;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                quo <= q_nx;
                rem <= r_nx;
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/r_exec_unit.sv
// R-type execute unit: RV32I/64I base ops, optional M extension.
module r_exec_unit
    import riscv_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter bit ENABLE_M    = 1'b1,
    parameter int MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_func,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_tag,
    output logic            out_illegal
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {K_IMM, K_MUL, K_DIV} kind_t;

    exec_state_t     state, state_n, tgt;
    kind_t           kind;
    logic            accept, ill, sgn, a_sgn, b_sgn;
    logic [XLEN-1:0] imm_res, mul_res, mag1, mag2, fix_res;
    logic [XLEN:0]   ma, mb;
    logic [2*XLEN-1:0] prod;
    logic [SW-1:0]   shamt;
    logic [2:0]      mul_cnt;
    logic            neg_q, neg_r, is_rem;
    logic            div_start, div_busy, div_done;
    logic [XLEN-1:0] div_quo, div_rem;

    assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign div_start = accept && (kind == K_DIV);

    // Decode and single-cycle datapath, evaluated on the offered operands.
    always_comb begin
        imm_res = '0;
        kind    = K_IMM;
        ill     = 1'b0;
        shamt   = in_rs2[SW-1:0];
        sgn     = !in_func[0];
        a_sgn   = (in_func[1:0] == 2'b01) || (in_func[1:0] == 2'b10);
        b_sgn   = (in_func[1:0] == 2'b01);
        ma      = {a_sgn & in_rs1[XLEN-1], in_rs1};
        mb      = {b_sgn & in_rs2[XLEN-1], in_rs2};
        prod    = (2*XLEN)'($signed(ma) * $signed(mb));
        mul_res = (in_func[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        mag1    = (sgn && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
        mag2    = (sgn && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
        case (in_func)
            ADD:  imm_res = in_rs1 + in_rs2;
            SUB:  imm_res = in_rs1 - in_rs2;
            SLL:  imm_res = in_rs1 << shamt;
            SLT:  imm_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
            SLTU: imm_res = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
            XOR:  imm_res = in_rs1 ^ in_rs2;
            SRL:  imm_res = in_rs1 >> shamt;
            SRA:  imm_res = $signed(in_rs1) >>> shamt;
            OR:   imm_res = in_rs1 | in_rs2;
            AND:  imm_res = in_rs1 & in_rs2;
            MUL, MULH, MULHSU, MULHU: begin
                if (ENABLE_M) kind = K_MUL;
                else          ill  = 1'b1;
            end
            DIV, DIVU, REM, REMU: begin
                if (!ENABLE_M)
                    ill = 1'b1;
                else if (in_rs2 == '0)
                    imm_res = in_func[1] ? in_rs1 : '1;
                else if (sgn && in_rs1 == MIN_NEG && in_rs2 == '1)
                    imm_res = in_func[1] ? '0 : in_rs1;
                else
                    kind = K_DIV;
            end
            default: ill = 1'b1;
        endcase
    end

    // Next state; tgt is where a freshly accepted op goes.
    always_comb begin
        state_n = state;
        case (kind)
            K_MUL:   tgt = (MUL_LATENCY == 1) ? DONE : MUL_BUSY;
            K_DIV:   tgt = DIV_BUSY;
            default: tgt = DONE;
        endcase
        case (state)
            IDLE:     if (accept) state_n = tgt;
            MUL_BUSY: if (mul_cnt == 3'd1) state_n = DONE;
            DIV_BUSY: if (div_busy && div_done) state_n = DONE;
            DONE:     if (out_ready) state_n = accept ? tgt : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    assign fix_res = is_rem ? (neg_r ? -div_rem : div_rem)
                            : (neg_q ? -div_quo : div_quo);

    // State, captured op context and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            mul_cnt     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            is_rem      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                out_tag     <= in_tag;
                out_illegal <= ill;
                out_result  <= (kind == K_MUL) ? mul_res : imm_res;
                mul_cnt     <= 3'(MUL_LATENCY - 1);
                neg_q       <= sgn && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
                neg_r       <= sgn && in_rs1[XLEN-1];
                is_rem      <= in_func[1];
            end else if (state == MUL_BUSY) begin
                mul_cnt <= mul_cnt - 3'd1;
            end else if (state == DIV_BUSY && div_busy && div_done) begin
                out_result <= fix_res;
            end
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (mag1),
        .divisor  (mag2),
        .busy     (div_busy),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

endmodule

// File: tb/tb_r_exec_unit.sv
// Directed bench for r_exec_unit (XLEN=32, MUL_LATENCY=2) plus an ENABLE_M=0 copy.
module tb_r_exec_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [4:0]  in_func, in_tag;
    logic [31:0] in_rs1, in_rs2;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        m0_in_ready, m0_out_valid, m0_out_illegal;
    logic [31:0] m0_out_result;
    logic [4:0]  m0_out_tag;

    int vectors = 0;
    int errors  = 0;
    int lat;
    logic rdy_seen, hold_ok;

    always #5 clk = ~clk;

    r_exec_unit #(.XLEN(32), .ENABLE_M(1'b1), .MUL_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    r_exec_unit #(.XLEN(32), .ENABLE_M(1'b0), .MUL_LATENCY(2)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(m0_out_valid), .out_ready(out_ready), .out_result(m0_out_result),
        .out_tag(m0_out_tag), .out_illegal(m0_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one op for one clock; returns #1 after the accepting edge.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        in_func = f; in_rs1 = a; in_rs2 = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from accept to out_valid (1 = next cycle); notes any in_ready while busy.
    task automatic wait_out(output int l, output logic rdy);
        l = 1; rdy = 1'b0;
        while (!out_valid && l < 200) begin
            if (in_ready) rdy = 1'b1;
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_func = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_illegal", out_illegal, 0);
        rst = 1'b0; #1;
        chk("rst_ready_after", in_ready, 1);

        // Base ops back to back
        issue(ADD, 32'd7, 32'd5, 5'd1);
        chk("add_valid", out_valid, 1); chk("add", out_result, 32'd12);
        chk("add_tag", out_tag, 5'd1);  chk("add_ready", in_ready, 1);
        issue(SUB, 32'd5, 32'd7, 5'd2);
        chk("sub", out_result, 32'hFFFFFFFE); chk("sub_ready", in_ready, 1);
        issue(SRA, 32'h80000000, 32'd4, 5'd3);
        chk("sra", out_result, 32'hF8000000); chk("sra_valid", out_valid, 1);
        issue(SLTU, 32'd1, 32'hFFFFFFFF, 5'd4);
        chk("sltu", out_result, 32'd1); chk("sltu_tag", out_tag, 5'd4);
        issue(SLT, 32'hFFFFFFFF, 32'd1, 5'd5);
        chk("slt", out_result, 32'd1);
        issue(SLL, 32'h1, 32'h23, 5'd6);
        chk("sll_shamt", out_result, 32'h8);
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);

        // Multiplies
        issue(MULH, 32'h80000000, 32'h80000000, 5'd7);
        wait_out(lat, rdy_seen);
        chk("mulh_lat", lat, 2); chk("mulh", out_result, 32'h40000000);
        chk("mulh_tag", out_tag, 5'd7); chk("mulh_busy_ready", rdy_seen, 0);
        issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
        wait_out(lat, rdy_seen);
        chk("mulhsu_lat", lat, 2); chk("mulhsu", out_result, 32'hFFFFFFFF);
        issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9);
        wait_out(lat, rdy_seen);
        chk("mulhu", out_result, 32'hFFFFFFFE);
        issue(MUL, 32'hFFFFFFFD, 32'd7, 5'd10);
        wait_out(lat, rdy_seen);
        chk("mul", out_result, 32'hFFFFFFEB);

        // Iterative divides
        issue(DIV, 32'hFFFFFFF9, 32'd2, 5'd11);
        wait_out(lat, rdy_seen);
        chk("div_lat", lat, 33); chk("div_busy_ready", rdy_seen, 0);
        chk("div", out_result, 32'hFFFFFFFD); chk("div_tag", out_tag, 5'd11);
        issue(REM, 32'hFFFFFFF9, 32'd2, 5'd12);
        wait_out(lat, rdy_seen);
        chk("rem", out_result, 32'hFFFFFFFF);
        issue(DIVU, 32'd100, 32'd7, 5'd13);
        wait_out(lat, rdy_seen);
        chk("divu_lat", lat, 33); chk("divu", out_result, 32'd14);
        issue(REMU, 32'd100, 32'd7, 5'd14);
        wait_out(lat, rdy_seen);
        chk("remu", out_result, 32'd2);
        issue(REM, 32'd7, 32'hFFFFFFFE, 5'd15);
        wait_out(lat, rdy_seen);
        chk("rem_pos_neg", out_result, 32'd1);

        // Divide fast paths
        issue(DIV, 32'd5, 32'd0, 5'd16);
        chk("div0_valid", out_valid, 1); chk("div0", out_result, 32'hFFFFFFFF);
        issue(REM, 32'd5, 32'd0, 5'd17);
        chk("rem0_valid", out_valid, 1); chk("rem0", out_result, 32'd5);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd18);
        chk("divovf_valid", out_valid, 1); chk("divovf", out_result, 32'h80000000);
        issue(REM, 32'h80000000, 32'hFFFFFFFF, 5'd19);
        chk("removf_valid", out_valid, 1); chk("removf", out_result, 32'd0);
        @(posedge clk); #1;

        // Backpressure: result held, later inputs ignored
        out_ready = 1'b0;
        issue(XOR, 32'hF0, 32'h0F, 5'd20);
        hold_ok = 1'b1;
        in_valid = 1'b1; in_func = ADD;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid && out_result == 32'hFF && out_tag == 5'd20 && !in_ready))
                hold_ok = 1'b0;
            in_rs1 = $urandom; in_rs2 = $urandom; in_tag = 5'(i);
            @(posedge clk); #1;
        end
        chk("hold", hold_ok, 1);
        chk("hold_result", out_result, 32'hFF);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", out_valid, 0);

        // Illegal encodings
        issue(5'b11000, 32'd3, 32'd4, 5'd21);
        chk("ill_flag", out_illegal, 1); chk("ill_result", out_result, 0);
        chk("ill_tag", out_tag, 5'd21);
        issue(5'b10001, 32'd3, 32'd4, 5'd22);
        chk("ill_sub_f3", out_illegal, 1);
        issue(MUL, 32'd3, 32'd4, 5'd23);
        chk("nom_valid", m0_out_valid, 1); chk("nom_ill", m0_out_illegal, 1);
        chk("nom_result", m0_out_result, 0); chk("nom_tag", m0_out_tag, 5'd23);
        wait_out(lat, rdy_seen);
        chk("mul_legal", out_illegal, 0); chk("mul_small", out_result, 32'd12);
        @(posedge clk); #1;

        // Reset in the middle of a divide
        issue(DIVU, 32'd100, 32'd7, 5'd24);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_result", out_result, 0);
        rst = 1'b0; #1;
        chk("midrst_ready_after", in_ready, 1);
        issue(ADD, 32'd1, 32'd1, 5'd25);
        chk("post_rst_valid", out_valid, 1); chk("post_rst_add", out_result, 32'd2);
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_quiet", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
